// File: rtl/side_buffer_pkg.sv
// Shared types and defaults for the MinBD side buffer.
// Holds the internal flit type, default sizing constants and the helper that
// sizes the head wait counter.
package side_buffer_pkg;

   localparam int WIDTH_FLIT_INT = 32;

   typedef logic [WIDTH_FLIT_INT-1:0] flit_int_t;

   localparam int SIDE_BUF_DEPTH      = 4;
   localparam int DEF_REDIRECT_THRESH = 2;

   // Wait counter must hold 0..thresh; a zero threshold still gets one bit.
   function automatic int wait_width(input int thresh);
      return (thresh < 1) ? 1 : $clog2(thresh + 1);
   endfunction

endpackage

// File: rtl/side_buffer_if.sv
// Handshake bundle between the eject-to-side-buffer stage / router pipeline
// (master) and the side buffer (slave).
// The ovf flag exists only when SIDE_BUF_OVF_CHK_EN is defined.
interface side_buffer_if;
   import side_buffer_pkg::*;

   flit_int_t din;
   logic      din_vld;
   logic      full;
   logic      redirect_req;
   logic      redirect_gnt;
   flit_int_t dout;
   logic      dout_vld;
`ifdef SIDE_BUF_OVF_CHK_EN
   logic      ovf;
`endif

`ifdef SIDE_BUF_OVF_CHK_EN
   modport master (
      output din, din_vld, redirect_gnt,
      input  full, redirect_req, dout, dout_vld, ovf
   );
   modport slave (
      input  din, din_vld, redirect_gnt,
      output full, redirect_req, dout, dout_vld, ovf
   );
`else
   modport master (
      output din, din_vld, redirect_gnt,
      input  full, redirect_req, dout, dout_vld
   );
   modport slave (
      input  din, din_vld, redirect_gnt,
      output full, redirect_req, dout, dout_vld
   );
`endif

endinterface

// File: rtl/side_buffer_fifo.sv
// side_buf_fifo: circular storage for the side buffer.
// Owns the memory, read/write pointers, occupancy count and the registered
// full flag. Pushes that arrive while full are dropped here; a pop that
// happens in the same cycle does not make room for them.
module side_buf_fifo
   import side_buffer_pkg::*;
#(
   parameter int DEPTH = SIDE_BUF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_req,
   input  logic                   pop,
   input  flit_int_t              wr_data,
   output flit_int_t              rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   flit_int_t      mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [AW:0]    count_next;
   logic           push;

   assign push    = push_req & ~full;
   assign rd_data = mem[rd_ptr];

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + (AW+1)'(1);
         2'b01:   count_next = count - (AW+1)'(1);
         default: count_next = count;
      endcase
   end

   // Pointers, count and full; pointers wrap naturally since DEPTH is 2^n.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
      end
   end

   // Storage is deliberately left uncleared by reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/side_buffer.sv
// side_buffer: MinBD side buffer top.
// Buffers flits deflected by the eject stage and offers the FIFO head back to
// the pipeline once it has waited REDIRECT_THRESH cycles. Popping happens on
// redirect_req & redirect_gnt; dout is masked to zero unless a pop occurs.
// Optional feature macro: SIDE_BUF_OVF_CHK_EN adds a sticky ovf flag and a
// simulation assertion on pushes attempted while full.
module side_buffer
   import side_buffer_pkg::*;
#(
   parameter int DEPTH           = SIDE_BUF_DEPTH,
   parameter int REDIRECT_THRESH = DEF_REDIRECT_THRESH
) (
   input logic         clk,
   input logic         rst,
   side_buffer_if.slave sb
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = wait_width(REDIRECT_THRESH);
   localparam logic [WW-1:0] THRESH_W = WW'(REDIRECT_THRESH);

   logic [CW-1:0] count;
   logic          fifo_full;
   logic          fifo_empty;
   flit_int_t     head;
   logic          pop;
   logic          head_ready;
   logic          req;
   logic [WW-1:0] wait_cnt;

   side_buf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_req (sb.din_vld),
      .pop      (pop),
      .wr_data  (sb.din),
      .rd_data  (head),
      .count    (count),
      .full     (fifo_full)
   );

   assign fifo_empty = (count == '0);

   generate
      if (REDIRECT_THRESH == 0) begin : g_no_wait
         assign head_ready = 1'b1;
      end else begin : g_wait
         assign head_ready = (wait_cnt >= THRESH_W);
      end
   endgenerate

   assign req = ~fifo_empty & head_ready;
   assign pop = req & sb.redirect_gnt;

   assign sb.redirect_req = req;
   assign sb.full         = fifo_full;
   assign sb.dout_vld     = pop;
   assign sb.dout         = pop ? head : '0;

   // Head wait counter: restarts for each new head, saturates once ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (fifo_empty || pop) begin
         wait_cnt <= '0;
      end else if (!head_ready) begin
         wait_cnt <= wait_cnt + WW'(1);
      end
   end

`ifdef SIDE_BUF_OVF_CHK_EN
   logic ovf_q;

   // Sticky overflow flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (sb.din_vld && fifo_full) begin
         ovf_q <= 1'b1;
      end
   end

   assign sb.ovf = ovf_q;

   ovf_chk : assert property (@(posedge clk) disable iff (rst) !(sb.din_vld && fifo_full))
      else $warning("side_buffer: push while full, flit dropped");
`endif

endmodule

// File: tb/tb_side_buffer.sv
// Self-checking bench for side_buffer (DEPTH=4, REDIRECT_THRESH=2).
// A queue-based reference model tracks buffered flits and how long the
// current head has waited; each test task compares DUT outputs against it
// or against explicit expected constants. ovf is checked when
// SIDE_BUF_OVF_CHK_EN is defined.
module tb_side_buffer;
   import side_buffer_pkg::*;

   localparam int DEPTH     = 4;
   localparam int THRESH    = 2;
   localparam int CYC_LIMIT = 20;

   logic clk;
   logic rst;

   side_buffer_if sb_if();

   side_buffer #(
      .DEPTH           (DEPTH),
      .REDIRECT_THRESH (THRESH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   int        checks;
   int        errors;
   flit_int_t mq[$];
   int        mwait;
   logic      movf;

   // Free-running clock, posedges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic m_req();
      return (mq.size() != 0) && (mwait >= THRESH);
   endfunction

   function automatic logic m_full();
      return (mq.size() == DEPTH);
   endfunction

   function automatic flit_int_t m_dout(input logic gnt);
      flit_int_t r;
      r = '0;
      if (m_req() && gnt) r = mq[0];
      return r;
   endfunction

   function automatic void m_reset();
      mq.delete();
      mwait = 0;
      movf  = 1'b0;
   endfunction

   // One clock edge of the reference behaviour.
   function automatic void m_edge(input logic vld, input flit_int_t d, input logic gnt);
      logic      do_pop;
      logic      do_push;
      logic      was_empty;
      flit_int_t tmp;
      do_pop    = m_req() && gnt;
      do_push   = vld && !m_full();
      was_empty = (mq.size() == 0);
      if (vld && m_full()) movf = 1'b1;
      if (do_pop) tmp = mq.pop_front();
      if (do_push) mq.push_back(d);
      if (was_empty || do_pop) mwait = 0;
      else mwait = mwait + 1;
   endfunction

   // Apply inputs just after an edge and settle before sampling.
   task automatic drive(input logic vld, input flit_int_t d, input logic gnt);
      sb_if.din_vld      = vld;
      sb_if.din          = d;
      sb_if.redirect_gnt = gnt;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge(sb_if.din_vld, sb_if.din, sb_if.redirect_gnt);
      #1;
   endtask

   // Hold grant until a pop is offered; leaves the cycle unticked for the caller.
   task automatic grant_until_valid(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < CYC_LIMIT; k++) begin
         drive(1'b0, '0, 1'b1);
         if (sb_if.dout_vld === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic drain_model();
      for (int k = 0; k < 60; k++) begin
         if (mq.size() == 0) break;
         drive(1'b0, '0, 1'b1);
         tick();
      end
   endtask

   task automatic test_reset();
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sb_if.full !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_full: got %b expected 0", sb_if.full);
      end
      checks++;
      if (sb_if.redirect_req !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_req: got %b expected 0", sb_if.redirect_req);
      end
      checks++;
      if (sb_if.dout_vld !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_dout_vld: got %b expected 0", sb_if.dout_vld);
      end
      checks++;
      if (sb_if.dout !== '0) begin
         errors++; $display("[TB] FAIL reset_dout: got %h expected 0", sb_if.dout);
      end
`ifdef SIDE_BUF_OVF_CHK_EN
      checks++;
      if (sb_if.ovf !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", sb_if.ovf);
      end
`endif
      tick();
   endtask

   task automatic test_threshold();
      flit_int_t a;
      logic      exp_req [4];
      a = $urandom;
      exp_req[0] = 1'b0;
      exp_req[1] = 1'b0;
      exp_req[2] = 1'b0;
      exp_req[3] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive((c == 0), (c == 0) ? a : '0, (c == 3));
         checks++;
         if (sb_if.redirect_req !== exp_req[c]) begin
            errors++;
            $display("[TB] FAIL thresh_req_c%0d: got %b expected %b", c, sb_if.redirect_req, exp_req[c]);
         end
         if (c == 3) begin
            checks++;
            if (sb_if.dout_vld !== 1'b1) begin
               errors++; $display("[TB] FAIL thresh_dout_vld: got %b expected 1", sb_if.dout_vld);
            end
            checks++;
            if (sb_if.dout !== a) begin
               errors++; $display("[TB] FAIL thresh_dout: got %h expected %h", sb_if.dout, a);
            end
         end
         tick();
      end
      drive(1'b0, '0, 1'b0);
      checks++;
      if (sb_if.redirect_req !== 1'b0) begin
         errors++; $display("[TB] FAIL thresh_after_pop_req: got %b expected 0", sb_if.redirect_req);
      end
      tick();
   endtask

   task automatic test_fill_overflow();
      flit_int_t fl [4];
      flit_int_t e;
      bit        ok;
      for (int i = 0; i < 4; i++) fl[i] = $urandom;
      e = $urandom;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, fl[i], 1'b0);
         checks++;
         if (sb_if.full !== 1'b0) begin
            errors++; $display("[TB] FAIL fill_full_early_%0d: got %b expected 0", i, sb_if.full);
         end
         tick();
      end
      drive(1'b1, e, 1'b0);
      checks++;
      if (sb_if.full !== 1'b1) begin
         errors++; $display("[TB] FAIL fill_full: got %b expected 1", sb_if.full);
      end
      tick();
      drive(1'b0, '0, 1'b0);
      checks++;
      if (sb_if.full !== 1'b1) begin
         errors++; $display("[TB] FAIL fill_full_after_drop: got %b expected 1", sb_if.full);
      end
`ifdef SIDE_BUF_OVF_CHK_EN
      checks++;
      if (sb_if.ovf !== 1'b1) begin
         errors++; $display("[TB] FAIL fill_ovf: got %b expected 1", sb_if.ovf);
      end
`endif
      tick();
      for (int i = 0; i < 4; i++) begin
         grant_until_valid(ok);
         checks++;
         if (!ok) begin
            errors++; $display("[TB] FAIL fill_drain_timeout_%0d: got no dout_vld expected 1", i);
         end else begin
            checks++;
            if (sb_if.dout !== fl[i]) begin
               errors++; $display("[TB] FAIL fill_order_%0d: got %h expected %h", i, sb_if.dout, fl[i]);
            end
         end
         tick();
         if (i == 0) begin
            drive(1'b0, '0, 1'b0);
            checks++;
            if (sb_if.full !== 1'b0) begin
               errors++; $display("[TB] FAIL fill_full_release: got %b expected 0", sb_if.full);
            end
            tick();
         end
      end
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sb_if.dout_vld !== 1'b0) begin
         errors++; $display("[TB] FAIL fill_dropped_flit_seen: got dout_vld %b expected 0", sb_if.dout_vld);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      flit_int_t x, y, z;
      bit        ok;
      bit        ready;
      x = $urandom; y = $urandom; z = $urandom;
      drive(1'b1, x, 1'b0); tick();
      drive(1'b1, y, 1'b0); tick();
      ready = 1'b0;
      for (int k = 0; k < CYC_LIMIT; k++) begin
         drive(1'b0, '0, 1'b0);
         if (sb_if.redirect_req === 1'b1) begin
            ready = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!ready) begin
         errors++; $display("[TB] FAIL simul_wait_timeout: got no redirect_req expected 1");
      end
      drive(1'b1, z, 1'b1);
      checks++;
      if (sb_if.dout_vld !== 1'b1 || sb_if.dout !== x) begin
         errors++;
         $display("[TB] FAIL simul_pop: got vld %b dout %h expected vld 1 dout %h", sb_if.dout_vld, sb_if.dout, x);
      end
      tick();
      drive(1'b0, '0, 1'b0);
      checks++;
      if (sb_if.redirect_req !== 1'b0) begin
         errors++; $display("[TB] FAIL simul_wait_restart: got %b expected 0", sb_if.redirect_req);
      end
      checks++;
      if (sb_if.full !== 1'b0) begin
         errors++; $display("[TB] FAIL simul_full: got %b expected 0", sb_if.full);
      end
      tick();
      grant_until_valid(ok);
      checks++;
      if (!ok || sb_if.dout !== y) begin
         errors++; $display("[TB] FAIL simul_second: got %h (ok=%0d) expected %h", sb_if.dout, ok, y);
      end
      tick();
      grant_until_valid(ok);
      checks++;
      if (!ok || sb_if.dout !== z) begin
         errors++; $display("[TB] FAIL simul_appended: got %h (ok=%0d) expected %h", sb_if.dout, ok, z);
      end
      tick();
      for (int k = 0; k < THRESH + 2; k++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (sb_if.dout_vld !== 1'b0) begin
            errors++; $display("[TB] FAIL simul_count_%0d: got dout_vld %b expected 0", k, sb_if.dout_vld);
         end
         tick();
      end
   endtask

   task automatic test_wrap_around();
      flit_int_t exp_q[$];
      flit_int_t d;
      flit_int_t expd;
      int        waited;
      bit        ok;
      d = $urandom;
      exp_q.push_back(d);
      drive(1'b1, d, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         d = $urandom;
         exp_q.push_back(d);
         drive(1'b1, d, 1'b0);
         checks++;
         if (sb_if.redirect_req !== 1'b0) begin
            errors++; $display("[TB] FAIL wrap_restart_%0d: got %b expected 0", i, sb_if.redirect_req);
         end
         tick();
         waited = 0;
         ok     = 1'b0;
         for (int k = 0; k < CYC_LIMIT; k++) begin
            drive(1'b0, '0, 1'b0);
            if (sb_if.redirect_req === 1'b1) begin
               ok = 1'b1;
               break;
            end
            waited++;
            tick();
         end
         checks++;
         if (!ok || waited != THRESH - 1) begin
            errors++; $display("[TB] FAIL wrap_wait_%0d: got %0d (ok=%0d) expected %0d", i, waited, ok, THRESH - 1);
         end
         drive(1'b0, '0, 1'b1);
         expd = exp_q.pop_front();
         checks++;
         if (sb_if.dout_vld !== 1'b1 || sb_if.dout !== expd) begin
            errors++;
            $display("[TB] FAIL wrap_data_%0d: got vld %b dout %h expected vld 1 dout %h", i, sb_if.dout_vld, sb_if.dout, expd);
         end
         tick();
      end
      grant_until_valid(ok);
      expd = exp_q.pop_front();
      checks++;
      if (!ok || sb_if.dout !== expd) begin
         errors++; $display("[TB] FAIL wrap_last: got %h (ok=%0d) expected %h", sb_if.dout, ok, expd);
      end
      tick();
   endtask

   task automatic test_spurious_grant();
      flit_int_t w;
      w = $urandom;
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sb_if.dout_vld !== 1'b0 || sb_if.dout !== '0) begin
         errors++; $display("[TB] FAIL spur_empty: got vld %b dout %h expected 0 0", sb_if.dout_vld, sb_if.dout);
      end
      tick();
      drive(1'b1, w, 1'b0);
      tick();
      for (int k = 0; k < THRESH; k++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (sb_if.dout_vld !== 1'b0 || sb_if.dout !== '0) begin
            errors++;
            $display("[TB] FAIL spur_waiting_%0d: got vld %b dout %h expected 0 0", k, sb_if.dout_vld, sb_if.dout);
         end
         tick();
      end
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sb_if.dout_vld !== 1'b1 || sb_if.dout !== w) begin
         errors++; $display("[TB] FAIL spur_head: got vld %b dout %h expected 1 %h", sb_if.dout_vld, sb_if.dout, w);
      end
      tick();
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sb_if.dout_vld !== 1'b0) begin
         errors++; $display("[TB] FAIL spur_after: got %b expected 0", sb_if.dout_vld);
      end
      tick();
   endtask

   task automatic test_random();
      logic      vld, gnt, e_full, e_req, e_vld;
      flit_int_t d, e_dout;
      for (int c = 0; c < 300; c++) begin
         vld = ($urandom_range(0, 99) < 55);
         gnt = ($urandom_range(0, 99) < 50);
         d   = $urandom;
         drive(vld, d, gnt);
         e_full = m_full();
         e_req  = m_req();
         e_vld  = e_req & gnt;
         e_dout = m_dout(gnt);
         checks++;
         if (sb_if.full !== e_full) begin
            errors++; $display("[TB] FAIL rand_full_c%0d: got %b expected %b", c, sb_if.full, e_full);
         end
         checks++;
         if (sb_if.redirect_req !== e_req) begin
            errors++; $display("[TB] FAIL rand_req_c%0d: got %b expected %b", c, sb_if.redirect_req, e_req);
         end
         checks++;
         if (sb_if.dout_vld !== e_vld) begin
            errors++; $display("[TB] FAIL rand_vld_c%0d: got %b expected %b", c, sb_if.dout_vld, e_vld);
         end
         checks++;
         if (sb_if.dout !== e_dout) begin
            errors++; $display("[TB] FAIL rand_dout_c%0d: got %h expected %h", c, sb_if.dout, e_dout);
         end
`ifdef SIDE_BUF_OVF_CHK_EN
         checks++;
         if (sb_if.ovf !== movf) begin
            errors++; $display("[TB] FAIL rand_ovf_c%0d: got %b expected %b", c, sb_if.ovf, movf);
         end
`endif
         tick();
      end
   endtask

   task automatic test_reset_mid();
      flit_int_t n;
      bit        ok;
      drain_model();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, flit_int_t'($urandom), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sb_if.dout_vld !== 1'b1) begin
         errors++; $display("[TB] FAIL rstmid_pre_vld: got %b expected 1", sb_if.dout_vld);
      end
      sb_if.din_vld = 1'b1;
      rst = 1'b1;
      m_reset();
      #1;
      checks++;
      if (sb_if.redirect_req !== 1'b0 || sb_if.dout_vld !== 1'b0 || sb_if.dout !== '0 || sb_if.full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_async: got req %b vld %b dout %h full %b expected all 0",
                  sb_if.redirect_req, sb_if.dout_vld, sb_if.dout, sb_if.full);
      end
      @(posedge clk);
      #1;
      checks++;
      if (sb_if.redirect_req !== 1'b0 || sb_if.dout_vld !== 1'b0 || sb_if.full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_held: got req %b vld %b full %b expected all 0",
                  sb_if.redirect_req, sb_if.dout_vld, sb_if.full);
      end
`ifdef SIDE_BUF_OVF_CHK_EN
      checks++;
      if (sb_if.ovf !== 1'b0) begin
         errors++; $display("[TB] FAIL rstmid_ovf: got %b expected 0", sb_if.ovf);
      end
`endif
      rst = 1'b0;
      m_reset();
      for (int k = 0; k < THRESH + 1; k++) begin
         drive(1'b0, '0, 1'b1);
         checks++;
         if (sb_if.redirect_req !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_empty_%0d: got %b expected 0", k, sb_if.redirect_req);
         end
         tick();
      end
      n = $urandom;
      drive(1'b1, n, 1'b0);
      tick();
      grant_until_valid(ok);
      checks++;
      if (!ok || sb_if.dout !== n) begin
         errors++; $display("[TB] FAIL rstmid_new_head: got %h (ok=%0d) expected %h", sb_if.dout, ok, n);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_reset();
      rst                = 1'b1;
      sb_if.din          = '0;
      sb_if.din_vld      = 1'b0;
      sb_if.redirect_gnt = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();

      test_reset();
      test_threshold();
      test_fill_overflow();
      test_back_to_back();
      test_wrap_around();
      test_spurious_grant();
      test_random();
      test_reset_mid();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/side_buffer.md
# side_buffer

MinBD side buffer: accepts the single deflected flit per cycle diverted by the eject-to-side-buffer stage, holds it in a small FIFO, and re-injects flits into the router pipeline through a redirect request/grant handshake. It sits directly downstream of the eject-to-side-buffer stage and returns `full` and `redirect_gnt` to that stage. A wait counter on the FIFO head enforces the MinBD redirection threshold, so buffered flits are not starved.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `REDIRECT_THRESH`, 2: cycles the head must wait before `redirect_req` is raised; 0 means request as soon as the FIFO is non-empty.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  flit_int_t  flit from the eject stage (`dout_side_buf`).
- `din_vld`  in  1  push strobe (`deflect_to_side_buf_vld`).
- `full`  out  1  FIFO full; registered.
- `redirect_req`  out  1  head flit is ready for redirection into the pipeline.
- `redirect_gnt`  in  1  pipeline accepts the head flit this cycle.
- `dout`  out  flit_int_t  head flit; `'0` when `dout_vld` is low.
- `dout_vld`  out  1  equals `redirect_req & redirect_gnt`.
- `ovf`  out  1  sticky overflow flag; present only with the macro below.

## Operation
- **Storage:** circular FIFO with `rd_ptr`/`wr_ptr` of log2(DEPTH) bits and `count` of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Push:** occurs when `din_vld & ~full`. The flit is written at `wr_ptr` and `wr_ptr` increments.
- **Push while full:** the flit is dropped and `count` is unchanged. Upstream gates on `~full`, so this is an error condition.
- **Pop:** occurs when `redirect_gnt & redirect_req`. `rd_ptr` increments. A `redirect_gnt` without `redirect_req` is ignored.
- **Simultaneous push and pop:** both take effect and `count` is unchanged. When full, the pop frees the slot on the next edge, not the current one, so the push is dropped. `full` is registered.
- **Wait counter `wait_cnt`:** log2(REDIRECT_THRESH+1) bits, minimum 1.
  - Cleared when the FIFO is empty or on a pop.
  - Otherwise increments, saturating at REDIRECT_THRESH.
- **Request:** `redirect_req = (count != 0) & (wait_cnt >= REDIRECT_THRESH)`.
- **Output:** `dout = dout_vld ? mem[rd_ptr] : '0`. The flit is presented unchanged (the eject stage has already cleared its top bit).
- **States (implicit):**
  - EMPTY (`count` == 0)
  - WAITING (non-empty, `wait_cnt` < THRESH)
  - READY (`redirect_req` high)
  - FULL is orthogonal to WAITING/READY.

## Timing
- **Reset values:** all pointers, `count`, `wait_cnt`, `full` and `ovf` = 0. Consequently `redirect_req`, `dout_vld` and `dout` are 0.
- **Reset mid-operation:** contents are discarded and storage is not cleared. Outputs are held at their reset values while `rst` is high.
- **Latency:**
  - A flit pushed at edge N into an empty FIFO, with THRESH=T, raises `redirect_req` in the cycle after edge N+T.
  - For T=0, `redirect_req` is high in the cycle after edge N.
- **Combinational paths:** `dout`/`dout_vld` depend combinationally on `redirect_gnt`; there are no other input-to-output paths.
- **`full`:** updates one edge after the push that fills the FIFO and deasserts one edge after a pop.
- **Back-to-back pops:** after a pop the next head restarts its wait from 0. With T>0, sustained redirection therefore occurs at most once per T+1 cycles.

## Configuration
- `SIDE_BUF_OVF_CHK_EN`:
  - **Defined:** port `ovf` exists. It is set on any push attempt while full, cleared only by `rst`. A simulation assertion fires on the same condition.
  - **Undefined:** `ovf` port and assertion are absent. Overflowing pushes are silently dropped.

## Structure
- `flit_int_t` and `WIDTH_FLIT_INT` come from flit.svh.
- `SIDE_BUF_DEPTH` and `REDIRECT_THRESH` defaults are constants in global.svh.
- One sub-module, `side_buf_fifo`: storage, pointers, `count` and `full`. `side_buffer` adds the wait counter, request logic, output masking and overflow check.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with 3 flits buffered → all outputs 0 immediately. After release, `count`=0 and no `redirect_req`.
- **Threshold:** push flit A (DEPTH=4, T=2) at edge 0 → `redirect_req` first high after edge 2. Gnt then gives `dout`=A and `dout_vld`=1.
- **Fill and overflow:** push 4 flits with no grants → `full`=1 after edge 3. A 5th push is dropped. `ovf`=1 with `SIDE_BUF_OVF_CHK_EN` defined; FIFO order A,B,C,D is preserved.
- **Simultaneous push and pop:** 2 flits buffered, `redirect_req` high; `din_vld` and `redirect_gnt` in the same cycle → `count` stays 2. The head advances and the new flit is appended at the tail.
- **Wrap-around:** 10 push/pop pairs through DEPTH=4 → flits emerge in push order across pointer wrap. `wait_cnt` restarts after every pop.
- **Spurious grant:** `redirect_gnt`=1 while WAITING or EMPTY → `dout_vld`=0, `dout`=0, and pointers are unchanged.
